local_port_injection_arbiter: RTL
=================================

// Module: local_port_injection_arbiter
// PURPOSE
//  Shares one router Local input port between NUM_REQ packet injectors (PEs) on the same tile.
//  - Upstream side: accepts each injector's Req/Grant handshake.
//  - Downstream side: drives the router's ReqDnStr/GntDnStr/DnStrFull handshake.
//  - Latches the winning injector's 32-bit packet word and presents it on PacketOut until the router grants it.
//  - Fairness: round-robin between injectors, one packet per grant.
// PARAMETERS
//  NUM_REQ    4   number of upstream injectors (2..8)
//  dataWidth  32  packet word width
//  IDW        2   width of ActiveID; must be >= clog2(NUM_REQ)
// PORTS
//  clk        in   1                  single clock; all logic on posedge
//  reset      in   1                  synchronous, active-high reset
//  ReqUpStr   in   NUM_REQ            per-injector request, held until its GntUpStr is seen
//  PacketIn   in   NUM_REQ*dataWidth  flattened packet words; slice i = [i*dataWidth +: dataWidth]
//  GntUpStr   out  NUM_REQ            per-injector grant, one-hot or zero
//  ReqDnStr   out  1                  request to router Local port
//  GntDnStr   in   1                  grant from router
//  DnStrFull  in   1                  router Local FIFO full
//  PacketOut  out  dataWidth          latched packet word of the current winner
//  ActiveID   out  IDW                index of the current or last winner
//  GrantCnt   out  NUM_REQ*16         per-injector forwarded-packet counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=1 at posedge): all outputs go to 0; state=IDLE; rr_ptr=NUM_REQ-1, so injector 0 has first priority.
//  FSM states: IDLE -> SEND -> RELEASE -> IDLE. All outputs are registered.
//  IDLE:
//   - If |ReqUpStr && !DnStrFull: winner = first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
//   - On that edge: PacketOut <= PacketIn[winner]; ActiveID <= winner; ReqDnStr <= 1; go to SEND.
//   - Latency: request sampled at edge N -> ReqDnStr high after edge N.
//   - If DnStrFull=1, or no request is present: stay in IDLE; GntDnStr is ignored.
//  SEND:
//   - ReqDnStr and PacketOut are held stable.
//   - On GntDnStr=1: ReqDnStr <= 0; GntUpStr[ActiveID] <= 1; rr_ptr <= ActiveID; go to RELEASE.
//   - DnStrFull rising while in SEND: keep requesting; do not abort.
//   - ReqUpStr[ActiveID] dropping while in SEND: the packet is still delivered (it is already latched).
//  RELEASE:
//   - GntUpStr[ActiveID] stays high until ReqUpStr[ActiveID]=0 is sampled.
//   - On that edge: GntUpStr <= 0; go to IDLE. Other injectors' requests are not evaluated here.
//  Throughput: best case 4 cycles per packet (IDLE, SEND with immediate grant, RELEASE x2).
//  Invariants:
//   - GntUpStr is one-hot or zero.
//   - ReqDnStr and GntUpStr are never high in the same cycle.
//  Reset asserted mid-operation: the in-flight packet is discarded, ReqDnStr drops the next cycle, and no grant is issued.
// CONFIGURATION
//  Macro INJ_ARB_STATS_EN:
//   - Defined: one 16-bit counter per injector in GrantCnt, incremented on the SEND->RELEASE edge.
//     Counters wrap at 0xFFFF -> 0x0000 and are cleared by reset.
//   - Undefined: no counter registers are built; GrantCnt is tied to 0.
// STRUCTURE
//  Package inj_arb_pkg:
//   - FSM state localparams (IDLE=2'b00, SEND=2'b01, RELEASE=2'b10)
//   - CNT_W=16
//   - clog2 function
//  Sub-module rr_priority_picker (combinational): inputs req[NUM_REQ] and ptr; outputs winner index and a valid flag.
//  Top level contains the FSM, packet latch and counters.
// TESTING
//  1 Reset: hold reset 3 cycles with all requests high -> all outputs 0 while reset=1; first winner after release is 0.
//  2 Single request: ReqUpStr=4'b0100, PacketIn[2]=32'hA5A5_0002, GntDnStr returned 2 cycles after ReqDnStr
//    -> ReqDnStr high 1 cycle after the request; PacketOut=A5A5_0002; ActiveID=2; GntUpStr=4'b0100 after the grant.
//  3 Fairness: ReqUpStr=4'b1111 held, each injector re-requests immediately
//    -> winners 0,1,2,3,0 in order; each GntUpStr is one-hot.
//  4 Full: DnStrFull=1 in IDLE with ReqUpStr=4'b0001 -> ReqDnStr stays 0.
//    Then DnStrFull=0 -> ReqDnStr asserts on the next edge.
//  5 Mid-operation reset: pulse reset in SEND with ActiveID=1 -> ReqDnStr=0 next cycle; GntUpStr never asserts; rr_ptr=3.
//  6 Stats (INJ_ARB_STATS_EN): 0x10000 grants to injector 0 -> GrantCnt[15:0]=0 (wrap); other counters unchanged.

Source files
------------

// File: rtl/inj_arb_pkg.sv
// Shared definitions for the local-port injection arbiter.
// FSM encodings, counter width and an elaboration-time clog2 helper.
package inj_arb_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] SEND    = 2'b01;
    localparam logic [1:0] RELEASE = 2'b10;

    localparam int CNT_W = 16;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first request above ptr, wrapping.
// Reports the winning index and whether any request was present.
module rr_priority_picker
    import inj_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               valid
);

    if (IDW < clog2(NUM_REQ)) begin : g_idw_check
        $error("IDW too narrow for NUM_REQ");
    end

    logic           hi_v;
    logic           lo_v;
    logic [IDW-1:0] hi_w;
    logic [IDW-1:0] lo_w;

    // Lowest set bit above ptr wins; otherwise lowest set bit overall.
    always_comb begin
        hi_v = 1'b0;
        lo_v = 1'b0;
        hi_w = '0;
        lo_w = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_v = 1'b1;
                lo_w = IDW'(i);
                if (i > int'(ptr)) begin
                    hi_v = 1'b1;
                    hi_w = IDW'(i);
                end
            end
        end
        valid  = lo_v;
        winner = hi_v ? hi_w : lo_w;
    end

endmodule

// File: rtl/local_port_injection_arbiter.sv
// Shares one router Local port between NUM_REQ injectors, round-robin.
// Optional per-injector grant counters when INJ_ARB_STATS_EN is defined.
module local_port_injection_arbiter
    import inj_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int dataWidth = 32,
    parameter int IDW       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           ReqUpStr,
    input  logic [NUM_REQ*dataWidth-1:0] PacketIn,
    output logic [NUM_REQ-1:0]           GntUpStr,
    output logic                         ReqDnStr,
    input  logic                         GntDnStr,
    input  logic                         DnStrFull,
    output logic [dataWidth-1:0]         PacketOut,
    output logic [IDW-1:0]               ActiveID,
    output logic [NUM_REQ*CNT_W-1:0]     GrantCnt
);

    logic [1:0]           state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [dataWidth-1:0] pkt_q, pkt_d;
    logic [IDW-1:0]       id_q, id_d;
    logic                 req_dn_q, req_dn_d;
    logic [NUM_REQ-1:0]   gnt_up_q, gnt_up_d;

    logic [IDW-1:0]       win;
    logic                 win_v;
    logic [dataWidth-1:0] pkt_sel;
    logic [NUM_REQ-1:0]   act_oh;
    logic                 act_req;
    logic                 fire;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req    (ReqUpStr),
        .ptr    (rr_ptr_q),
        .winner (win),
        .valid  (win_v)
    );

    // Winner's packet word and one-hot decode of the active injector.
    always_comb begin
        pkt_sel = '0;
        act_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i)) pkt_sel = PacketIn[i*dataWidth +: dataWidth];
            act_oh[i] = (id_q == IDW'(i));
        end
        act_req = |(ReqUpStr & act_oh);
        fire    = (state_q == SEND) && GntDnStr;
    end

    // IDLE picks and latches, SEND waits for the router, RELEASE waits for the injector.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        pkt_d    = pkt_q;
        id_d     = id_q;
        req_dn_d = req_dn_q;
        gnt_up_d = gnt_up_q;
        case (state_q)
            IDLE: begin
                if (win_v && !DnStrFull) begin
                    pkt_d    = pkt_sel;
                    id_d     = win;
                    req_dn_d = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    req_dn_d = 1'b0;
                    gnt_up_d = act_oh;
                    rr_ptr_d = id_q;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                if (!act_req) begin
                    gnt_up_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                req_dn_d = 1'b0;
                gnt_up_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State registers; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDW'(NUM_REQ - 1);
            pkt_q    <= '0;
            id_q     <= '0;
            req_dn_q <= 1'b0;
            gnt_up_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            pkt_q    <= pkt_d;
            id_q     <= id_d;
            req_dn_q <= req_dn_d;
            gnt_up_q <= gnt_up_d;
        end
    end

    assign GntUpStr  = gnt_up_q;
    assign ReqDnStr  = req_dn_q;
    assign PacketOut = pkt_q;
    assign ActiveID  = id_q;

`ifdef INJ_ARB_STATS_EN
    logic [NUM_REQ*CNT_W-1:0] cnt_q, cnt_d;

    // Count one forwarded packet for the active injector; wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire && act_oh[i]) begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign GrantCnt = cnt_q;
`else
    assign GrantCnt = '0;
`endif

endmodule
